// File: rtl/keypad_encoder10to4_if.sv
// Keypad encoder bus: raw key lines and enable/ack in, captured BCD code and status out.
//   enable  : gates capture of new keypresses
//   enc_in  : raw active-high key lines, bit i = digit i, asynchronous to clk
//   ack     : consumer accepts the current code (sampled only while valid=1)
//   enc_out : registered BCD digit of the captured key
//   valid   : enc_out holds an unconsumed keypress
//   multi   : more than one key line was high at capture
//   busy    : encoder is not idle
interface keypad_encoder10to4_if;
  logic       enable;
  logic [9:0] enc_in;
  logic       ack;
  logic [3:0] enc_out;
  logic       valid;
  logic       multi;
  logic       busy;

  modport master (
    output enable, enc_in, ack,
    input  enc_out, valid, multi, busy
  );

  modport slave (
    input  enable, enc_in, ack,
    output enc_out, valid, multi, busy
  );
endinterface

// File: rtl/keypad_encoder10to4.sv
// 10-line keypad to BCD encoder with synchroniser, debounce and valid/ack delivery.
// Each debounced keypress is delivered exactly once; the key must be debounced
// as released before another capture can occur.
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   bus   : keypad_encoder10to4_if.slave (enable, enc_in, ack -> enc_out, valid, multi, busy)
module keypad_encoder10to4 #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  keypad_encoder10to4_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_d;
  logic [9:0]       s1, sync;
  logic [9:0]       snapshot, snapshot_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             multi_q, multi_d;

  // Lowest set bit wins, so digit 0 has highest priority.
  function automatic logic [3:0] lowest_idx(input logic [9:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 10; i > 0; i--) begin
      if (v[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [9:0] v);
    return (v & (v - 10'd1)) != '0;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= bus.enc_in;
      sync <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      snapshot <= '0;
      cnt      <= '0;
      code_q   <= '0;
      multi_q  <= 1'b0;
    end else begin
      state    <= state_d;
      snapshot <= snapshot_d;
      cnt      <= cnt_d;
      code_q   <= code_d;
      multi_q  <= multi_d;
    end
  end

  always_comb begin
    state_d    = state;
    snapshot_d = snapshot;
    cnt_d      = cnt;
    code_d     = code_q;
    multi_d    = multi_q;
    case (state)
      IDLE: begin
        if (bus.enable && sync != '0) begin
          snapshot_d = sync;
          cnt_d      = '0;
          state_d    = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!bus.enable || sync == '0) begin
          state_d = IDLE;
        end else if (sync != snapshot) begin
          snapshot_d = sync;
          cnt_d      = '0;
        end else if (cnt == CNT_LAST) begin
          code_d  = lowest_idx(snapshot);
          multi_d = more_than_one(snapshot);
          state_d = HOLD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // enable is deliberately not consulted: a captured code waits for ack.
        if (bus.ack) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (sync != '0) begin
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // valid is exactly the HOLD state: it is set on entry and cleared on the ack edge.
  assign bus.enc_out = code_q;
  assign bus.valid   = (state == HOLD);
  assign bus.multi   = multi_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_keypad_encoder10to4.sv
module tb_keypad_encoder10to4;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  keypad_encoder10to4_if bus();

  keypad_encoder10to4 #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  // Reference model: run-length view of the synchronised key lines.
  // phase 0 = waiting for a press, 1 = code pending, 2 = waiting for release.
  int         m_phase, m_run, m_zero;
  logic [9:0] m_last, m_s1, m_sync;
  logic [3:0] m_code;
  logic       m_multi;

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_zero = 0;
    m_last = '0; m_s1 = '0; m_sync = '0;
    m_code = '0; m_multi = 1'b0;
  endtask

  task automatic model_step();
    int lsb;
    case (m_phase)
      0: begin
        if (bus.enable && m_sync != 0) begin
          m_run  = (m_run > 0 && m_sync == m_last) ? m_run + 1 : 1;
          m_last = m_sync;
        end else begin
          m_run = 0;
        end
        // D+1 identical enabled samples make a press.
        if (m_run == D + 1) begin
          lsb     = int'(m_sync & (~m_sync + 10'd1));
          m_code  = 4'($clog2(lsb));
          m_multi = ($countones(m_sync) > 1);
          m_phase = 1;
          m_run   = 0;
        end
      end
      1: if (bus.ack) begin m_phase = 2; m_zero = 0; end
      default: begin
        if (m_sync == 0) begin
          m_zero++;
          if (m_zero == D) m_phase = 0;
        end else begin
          m_zero = 0;
        end
      end
    endcase
    m_sync = m_s1;
    m_s1   = bus.enc_in;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(input int limit, input string name);
    int n = 0;
    while (bus.valid !== 1'b1 && n < limit) begin step(); n++; end
    check(name, 32'(bus.valid), 1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < limit) begin step(); n++; end
    check(name, 32'(bus.busy), 0);
  endtask

  // Runs n cycles and reports how many had valid high.
  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.valid === 1'b1) seen++;
    end
  endtask

  typedef struct {
    logic [9:0] keys;
    logic [3:0] code;
    logic       multi;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int seen, rises;
    logic prev_v;

    for (int i = 0; i < 10; i++) begin
      vecs[i].keys  = 10'(1 << i);
      vecs[i].code  = 4'(i);
      vecs[i].multi = 1'b0;
    end
    vecs[10] = '{10'h3FF, 4'd0, 1'b1};
    vecs[11] = '{10'h300, 4'd8, 1'b1};
    vecs[12] = '{10'h201, 4'd0, 1'b1};
    vecs[13] = '{10'h240, 4'd6, 1'b1};
    vecs[14] = '{10'h00C, 4'd2, 1'b1};

    // 1) reset with key 9 held, then latency
    rst_n = 1'b0;
    bus.enable = 1'b1; bus.enc_in = 10'h200; bus.ack = 1'b0;
    model_reset();
    step(); step();
    check("rst_enc_out", 32'(bus.enc_out), 0);
    check("rst_valid",   32'(bus.valid), 0);
    check("rst_multi",   32'(bus.multi), 0);
    check("rst_busy",    32'(bus.busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("t1_valid_before_E6", 32'(bus.valid), 0);
    step();
    check("t1_valid_at_E6", 32'(bus.valid), 1);
    check("t1_enc_out", 32'(bus.enc_out), 9);
    check("t1_multi",   32'(bus.multi), 0);
    bus.ack = 1'b1;
    step();
    check("t1_valid_after_ack", 32'(bus.valid), 0);
    bus.ack = 1'b0; bus.enc_in = '0;
    wait_idle(30, "t1_idle");
    check("t1_code_kept", 32'(bus.enc_out), 9);

    // 2) short glitch
    bus.enc_in = 10'b0000000100;
    step(); step(); step();
    bus.enc_in = '0;
    count_valid(15, seen);
    check("t2_glitch_no_valid", 32'(seen), 0);
    check("t2_busy_idle", 32'(bus.busy), 0);

    // 3) two keys, ack, held key does not repeat
    bus.enc_in = 10'b0000100010;
    wait_valid(20, "t3_valid");
    check("t3_enc_out", 32'(bus.enc_out), 1);
    check("t3_multi",   32'(bus.multi), 1);
    bus.ack = 1'b1;
    step();
    check("t3_valid_drop", 32'(bus.valid), 0);
    bus.ack = 1'b0;
    count_valid(20, seen);
    check("t3_no_repeat", 32'(seen), 0);
    bus.enc_in = '0;
    wait_idle(30, "t3_idle");

    // 4) ack tied high, digit 3 twice
    bus.ack = 1'b1;
    seen = 0; rises = 0; prev_v = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 20; i++) begin
        bus.enc_in = (i < 10) ? 10'h008 : 10'h000;
        step();
        if (bus.valid === 1'b1) begin
          seen++;
          check("t4_enc_out", 32'(bus.enc_out), 3);
        end
        if (bus.valid === 1'b1 && prev_v !== 1'b1) rises++;
        prev_v = bus.valid;
      end
    end
    check("t4_valid_cycles", 32'(seen), 2);
    check("t4_valid_pulses", 32'(rises), 2);
    bus.ack = 1'b0;
    wait_idle(30, "t4_idle");

    // 5) enable ignored in HOLD, blocks capture in IDLE
    bus.enc_in = 10'h020;
    wait_valid(20, "t5_valid");
    bus.enable = 1'b0;
    count_valid(6, seen);
    check("t5_hold_keeps_valid", 32'(seen), 6);
    check("t5_enc_out", 32'(bus.enc_out), 5);
    bus.ack = 1'b1;
    step();
    check("t5_valid_drop", 32'(bus.valid), 0);
    bus.ack = 1'b0; bus.enc_in = '0;
    wait_idle(30, "t5_idle");
    bus.enc_in = 10'h020;
    count_valid(15, seen);
    check("t5_disabled_no_valid", 32'(seen), 0);
    check("t5_disabled_busy", 32'(bus.busy), 0);
    bus.enc_in = '0; bus.enable = 1'b1;
    step(); step(); step();

    // 6) reset during DEBOUNCE and during HOLD
    bus.enc_in = 10'h080;
    step(); step(); step();
    check("t6_in_debounce", 32'(bus.busy), 1);
    rst_n = 1'b0; bus.enc_in = '0;
    model_reset();
    #1;
    check("t6a_valid", 32'(bus.valid), 0);
    check("t6a_busy",  32'(bus.busy), 0);
    #2 rst_n = 1'b1;
    count_valid(15, seen);
    check("t6a_no_late_valid", 32'(seen), 0);
    bus.enc_in = 10'h004;
    wait_valid(20, "t6b_valid");
    rst_n = 1'b0; bus.enc_in = '0;
    model_reset();
    #1;
    check("t6b_valid",   32'(bus.valid), 0);
    check("t6b_busy",    32'(bus.busy), 0);
    check("t6b_enc_out", 32'(bus.enc_out), 0);
    #2 rst_n = 1'b1;
    count_valid(15, seen);
    check("t6b_no_late_valid", 32'(seen), 0);

    // table of key patterns
    foreach (vecs[k]) begin
      bus.enc_in = vecs[k].keys;
      wait_valid(20, $sformatf("vec%0d_valid", k));
      check($sformatf("vec%0d_enc_out", k), 32'(bus.enc_out), 32'(vecs[k].code));
      check($sformatf("vec%0d_multi", k),   32'(bus.multi),   32'(vecs[k].multi));
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0; bus.enc_in = '0;
      wait_idle(30, $sformatf("vec%0d_idle", k));
    end

    // randomized segments against the reference model
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 300; s++) begin
      int kind, dur;
      logic [9:0] keys;
      kind = $urandom_range(0, 9);
      dur  = $urandom_range(1, 12);
      if (kind < 2)      keys = '0;
      else if (kind < 7) keys = 10'(1 << $urandom_range(0, 9));
      else begin
        keys = 10'($urandom_range(1, 1023));
        if (kind == 9) dur = $urandom_range(1, D);
      end
      for (int c = 0; c < dur; c++) begin
        bus.enc_in = keys;
        bus.enable = ($urandom_range(0, 9) != 0);
        bus.ack    = ($urandom_range(0, 3) == 0);
        step();
        check("rnd_valid", 32'(bus.valid), 32'(m_phase == 1));
        check("rnd_busy",  32'(bus.busy),  32'(m_phase != 0 || m_run > 0));
        check("rnd_enc_out", 32'(bus.enc_out), 32'(m_code));
        check("rnd_multi", 32'(bus.multi), 32'(m_multi));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
